// File: rtl/pkt_parser_pkg.sv
// Shared types and helpers for the packet-parser datapath.
package pkt_parser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    PAY_FIRST,
    PAY
  } split_state_t;

  localparam int unsigned DEFAULT_ID_WIDTH = 32;

  // Header length of 0 means a single header beat; oversize values saturate.
  function automatic int unsigned clamp_hdr_beats(input int unsigned value,
                                                  input int unsigned max_beats);
    if (value == 0) return 1;
    if (value > max_beats) return max_beats;
    return value;
  endfunction

endpackage

// File: rtl/pkt_stat_cnt.sv
// Wrapping statistics counter with synchronous reset and increment enable.
module pkt_stat_cnt #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/split_header_payload.sv
// Splits each inbound Avalon-ST packet into a header stream (first H beats) and a payload
// stream (remaining beats), with per-packet H, optional payload discard and statistics.
module split_header_payload
  import pkt_parser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned MAX_HEADER_BEATS = 4,
  parameter int unsigned ID_WIDTH         = DEFAULT_ID_WIDTH,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter int unsigned EMPTY_WIDTH      = $clog2(DATA_WIDTH / 8)
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_sop,
  input  logic                                  in_eop,
  input  logic                                  in_error,
  input  logic [EMPTY_WIDTH-1:0]                in_empty,
  input  logic [DATA_WIDTH-1:0]                 in_data,

  output logic                                  hdr_out_valid,
  input  logic                                  hdr_out_ready,
  output logic                                  hdr_out_sop,
  output logic                                  hdr_out_eop,
  output logic                                  hdr_out_error,
  output logic [EMPTY_WIDTH-1:0]                hdr_out_empty,
  output logic [DATA_WIDTH-1:0]                 hdr_out_data,

  output logic                                  pay_out_valid,
  input  logic                                  pay_out_ready,
  output logic                                  pay_out_sop,
  output logic                                  pay_out_eop,
  output logic                                  pay_out_error,
  output logic [EMPTY_WIDTH-1:0]                pay_out_empty,
  output logic [DATA_WIDTH-1:0]                 pay_out_data,

  input  logic [$clog2(MAX_HEADER_BEATS+1)-1:0] i_hdr_beats,
  input  logic                                  i_drop_payload,
  output logic [ID_WIDTH-1:0]                   o_id,
  output logic                                  o_in_payload,
  output logic [CNT_WIDTH-1:0]                  o_pkt_cnt,
  output logic [CNT_WIDTH-1:0]                  o_drop_cnt,
  output logic [CNT_WIDTH-1:0]                  o_orphan_cnt
);

  localparam int unsigned HBW = $clog2(MAX_HEADER_BEATS + 1);

  split_state_t  state_q, state_d;
  logic [HBW-1:0] beat_cnt_q, beat_cnt_d;
  logic [HBW-1:0] hdr_beats_q, hdr_beats_d;
  logic [HBW-1:0] hdr_beats_sel;
  logic           drop_q, drop_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  logic hdr_sel;
  logic pay_sel;
  logic hdr_sop;
  logic force_eop;
  logic pkt_inc;
  logic drop_inc;
  logic orphan_inc;

  assign hdr_beats_sel = HBW'(clamp_hdr_beats(32'(i_hdr_beats), MAX_HEADER_BEATS));

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hdr_beats_d = hdr_beats_q;
    drop_d      = drop_q;
    id_d        = id_q;
    in_ready    = 1'b0;
    hdr_sel     = 1'b0;
    pay_sel     = 1'b0;
    hdr_sop     = 1'b0;
    force_eop   = 1'b0;
    pkt_inc     = 1'b0;
    drop_inc    = 1'b0;
    orphan_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_sop) begin
          in_ready  = hdr_out_ready;
          hdr_sel   = in_valid;
          hdr_sop   = 1'b1;
          force_eop = !in_eop && (hdr_beats_sel == HBW'(1));
          if (in_valid && hdr_out_ready) begin
            hdr_beats_d = hdr_beats_sel;
            drop_d      = i_drop_payload;
            id_d        = in_data[DATA_WIDTH-2 -: ID_WIDTH];
            pkt_inc     = 1'b1;
            beat_cnt_d  = HBW'(1);
            if (in_eop) begin
              state_d = IDLE;
            end else if (force_eop) begin
              state_d = PAY_FIRST;
            end else begin
              state_d = HEAD;
            end
          end
        end else begin
          // Beats outside a packet are swallowed so ingress never stalls on them.
          in_ready   = 1'b1;
          orphan_inc = in_valid;
        end
      end
      HEAD: begin
        in_ready  = hdr_out_ready;
        hdr_sel   = in_valid;
        force_eop = !in_eop && ((beat_cnt_q + HBW'(1)) == hdr_beats_q);
        if (in_valid && hdr_out_ready) begin
          beat_cnt_d = beat_cnt_q + HBW'(1);
          if (in_eop) begin
            state_d = IDLE;
          end else if (force_eop) begin
            state_d = PAY_FIRST;
          end
        end
      end
      PAY_FIRST, PAY: begin
        if (drop_q) begin
          in_ready = 1'b1;
          drop_inc = in_valid;
        end else begin
          in_ready = pay_out_ready;
          pay_sel  = in_valid;
        end
        if (in_valid && in_ready) begin
          state_d = in_eop ? IDLE : PAY;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      in_ready   = 1'b0;
      hdr_sel    = 1'b0;
      pay_sel    = 1'b0;
      pkt_inc    = 1'b0;
      drop_inc   = 1'b0;
      orphan_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      hdr_beats_q <= '0;
      drop_q      <= 1'b0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      hdr_beats_q <= hdr_beats_d;
      drop_q      <= drop_d;
      id_q        <= id_d;
    end
  end

  // Unselected port drives every field to zero.
  assign hdr_out_valid = hdr_sel;
  assign hdr_out_sop   = hdr_sel & hdr_sop;
  assign hdr_out_eop   = hdr_sel & (in_eop | force_eop);
  assign hdr_out_error = hdr_sel & in_error;
  assign hdr_out_empty = (hdr_sel && !force_eop) ? in_empty : '0;
  assign hdr_out_data  = hdr_sel ? in_data : '0;

  assign pay_out_valid = pay_sel;
  assign pay_out_sop   = pay_sel & (state_q == PAY_FIRST);
  assign pay_out_eop   = pay_sel & in_eop;
  assign pay_out_error = pay_sel & in_error;
  assign pay_out_empty = pay_sel ? in_empty : '0;
  assign pay_out_data  = pay_sel ? in_data : '0;

  assign o_id         = id_q;
  assign o_in_payload = (state_q == PAY_FIRST) || (state_q == PAY);

  pkt_stat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_pkt_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (pkt_inc),
    .count(o_pkt_cnt)
  );

  pkt_stat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_drop_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (drop_inc),
    .count(o_drop_cnt)
  );

  pkt_stat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_orphan_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (orphan_inc),
    .count(o_orphan_cnt)
  );

endmodule
